// File: rtl/mc_control_fsm_if.sv
// Bus between the multicycle control FSM and its datapath: opcode and memory
// handshake in, datapath steering and status out.
interface mc_control_fsm_if;
  logic [6:0] op;
  logic       mem_ready;
  logic       Branch;
  logic       PCUpdate;
  logic       RegWrite;
  logic       MemWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       mem_req;
  logic       retire;
  logic       fault;

  modport master (
    output op, mem_ready,
    input  Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc,
    input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, mem_req, retire, fault
  );

  modport slave (
    input  op, mem_ready,
    output Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, mem_req, retire, fault
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V style main controller with memory-stall timeout that
// halts in TRAP until reset.
module mc_control_fsm #(
  parameter int ENABLE_EXT = 1,
  parameter int MEM_WAIT   = 1,
  parameter int TIMEOUT    = 15
) (
  input  logic         clk,
  input  logic         reset,
  mc_control_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, JAL, BRANCH, JALR_A, JALR_B, LUI, AUIPC, TRAP
  } state_t;

  localparam logic [7:0] TMO = TIMEOUT[7:0];

  state_t     state;
  state_t     next;
  logic [7:0] stall_cnt;
  logic       ready;
  logic       mem_state;
  logic       enter_mem;
  logic       timed_out;

  function automatic state_t decode_op(input logic [6:0] opc);
    state_t s;
    case (opc)
      7'b0000011, 7'b0100011: s = MEMADR;
      7'b0110011:             s = EXECR;
      7'b0010011:             s = EXECI;
      7'b1101111:             s = JAL;
      7'b1100011:             s = BRANCH;
      7'b1100111:             s = (ENABLE_EXT != 0) ? JALR_A : TRAP;
      7'b0110111:             s = (ENABLE_EXT != 0) ? LUI : TRAP;
      7'b0010111:             s = (ENABLE_EXT != 0) ? AUIPC : TRAP;
      default:                s = TRAP;
    endcase
    return s;
  endfunction

  // Without wait support the memory is assumed to complete every cycle.
  assign ready     = (MEM_WAIT == 0) ? 1'b1 : bus.mem_ready;
  assign mem_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  assign enter_mem = (next != state) &&
                     ((next == FETCH) || (next == MEMREAD) || (next == MEMWRITE));
  assign timed_out = !ready && (stall_cnt == TMO);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      stall_cnt <= '0;
    end else begin
      state <= next;
      if (ready || enter_mem)
        stall_cnt <= '0;
      else if (mem_state)
        stall_cnt <= stall_cnt + 8'd1;
    end
  end

  always_comb begin
    next          = state;
    bus.Branch    = 1'b0;
    bus.PCUpdate  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ALUOp     = 2'b00;
    bus.mem_req   = 1'b0;
    bus.retire    = 1'b0;
    bus.fault     = 1'b0;
    case (state)
      FETCH: begin
        bus.mem_req   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = ready;
        bus.PCUpdate  = ready;
        if (ready)          next = DECODE;
        else if (timed_out) next = TRAP;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        next        = decode_op(bus.op);
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        next        = (bus.op == 7'b0000011) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.AdrSrc  = 1'b1;
        bus.mem_req = 1'b1;
        if (ready)          next = MEMWB;
        else if (timed_out) next = TRAP;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        bus.retire    = 1'b1;
        next          = FETCH;
      end
      MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.mem_req  = 1'b1;
        bus.MemWrite = ready;
        bus.retire   = ready;
        if (ready)          next = FETCH;
        else if (timed_out) next = TRAP;
      end
      EXECR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b10;
        next        = ALUWB;
      end
      EXECI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 2'b10;
        next        = ALUWB;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.retire   = 1'b1;
        next         = FETCH;
      end
      JAL: begin
        bus.ALUSrcA  = 2'b01;
        bus.ALUSrcB  = 2'b10;
        bus.PCUpdate = 1'b1;
        next         = ALUWB;
      end
      BRANCH: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUOp   = 2'b01;
        bus.Branch  = 1'b1;
        bus.retire  = 1'b1;
        next        = FETCH;
      end
      JALR_A: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        next        = JALR_B;
      end
      JALR_B: begin
        bus.ALUSrcA  = 2'b01;
        bus.ALUSrcB  = 2'b10;
        bus.PCUpdate = 1'b1;
        next         = ALUWB;
      end
      LUI: begin
        bus.ALUSrcA = 2'b11;
        bus.ALUSrcB = 2'b01;
        next        = ALUWB;
      end
      AUIPC: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        next        = ALUWB;
      end
      default: begin
        bus.fault = 1'b1;
        next      = TRAP;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized scoreboard bench for mc_control_fsm across three parameter sets
// (short timeout, extensions disabled, memory wait disabled).
module tb_mc_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_LD  = 7'b0000011, OP_ST  = 7'b0100011,
                         OP_R   = 7'b0110011, OP_I   = 7'b0010011,
                         OP_JAL = 7'b1101111, OP_BR  = 7'b1100011,
                         OP_JR  = 7'b1100111, OP_LUI = 7'b0110111,
                         OP_AUI = 7'b0010111;

  mc_control_fsm_if if0 ();
  mc_control_fsm_if if1 ();
  mc_control_fsm_if if2 ();

  logic [6:0] op_d  [3];
  logic       rdy_d [3];
  logic       rst_d [3];

  assign if0.op = op_d[0];  assign if0.mem_ready = rdy_d[0];
  assign if1.op = op_d[1];  assign if1.mem_ready = rdy_d[1];
  assign if2.op = op_d[2];  assign if2.mem_ready = rdy_d[2];

  mc_control_fsm #(.ENABLE_EXT(1), .MEM_WAIT(1), .TIMEOUT(3))
    u0 (.clk(clk), .reset(rst_d[0]), .bus(if0));
  mc_control_fsm #(.ENABLE_EXT(0), .MEM_WAIT(1), .TIMEOUT(15))
    u1 (.clk(clk), .reset(rst_d[1]), .bus(if1));
  mc_control_fsm #(.ENABLE_EXT(1), .MEM_WAIT(0), .TIMEOUT(15))
    u2 (.clk(clk), .reset(rst_d[2]), .bus(if2));

  int tmo [3] = '{3, 15, 15};
  bit ext [3] = '{1'b1, 1'b0, 1'b1};
  bit mw  [3] = '{1'b1, 1'b1, 1'b0};

  // {fault, retire, mem_req, Branch, PCUpdate, RegWrite, MemWrite, IRWrite,
  //  AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
  logic [16:0] vec [3];
  assign vec[0] = {if0.fault, if0.retire, if0.mem_req, if0.Branch, if0.PCUpdate,
                   if0.RegWrite, if0.MemWrite, if0.IRWrite, if0.AdrSrc,
                   if0.ResultSrc, if0.ALUSrcA, if0.ALUSrcB, if0.ALUOp};
  assign vec[1] = {if1.fault, if1.retire, if1.mem_req, if1.Branch, if1.PCUpdate,
                   if1.RegWrite, if1.MemWrite, if1.IRWrite, if1.AdrSrc,
                   if1.ResultSrc, if1.ALUSrcA, if1.ALUSrcB, if1.ALUOp};
  assign vec[2] = {if2.fault, if2.retire, if2.mem_req, if2.Branch, if2.PCUpdate,
                   if2.RegWrite, if2.MemWrite, if2.IRWrite, if2.AdrSrc,
                   if2.ResultSrc, if2.ALUSrcA, if2.ALUSrcB, if2.ALUOp};

  function automatic logic [16:0] mk(bit f, bit rt, bit mr, bit br, bit pc,
                                     bit rw, bit wr, bit ir, bit ad,
                                     logic [1:0] rs, logic [1:0] a,
                                     logic [1:0] b, logic [1:0] ao);
    return {f, rt, mr, br, pc, rw, wr, ir, ad, rs, a, b, ao};
  endfunction

  logic [16:0] V_FSTALL, V_FRDY, V_DEC, V_MADR, V_MRD, V_MWB, V_MWR_S, V_MWR_R,
               V_EXR, V_EXI, V_AWB, V_JAL, V_BR, V_JRA, V_JRB, V_LUI, V_AUI, V_TRAP;

  typedef struct {
    int          sel;
    logic [16:0] exp;
    bit          care;
    string       tag;
  } item_t;

  item_t sbq [$];
  int    total = 0;
  int    bad   = 0;
  bit    force_fs = 1'b0;

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  task automatic cyc(int sel, logic [6:0] op, logic rdy, logic rst,
                     logic [16:0] exp, bit care, string tag);
    item_t it;
    @(posedge clk);
    #1;
    op_d[sel]  = op;
    rdy_d[sel] = rdy;
    rst_d[sel] = rst;
    it.sel  = sel;
    it.exp  = exp;
    it.care = care;
    it.tag  = tag;
    sbq.push_back(it);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      item_t it;
      it = sbq.pop_front();
      if (it.care) begin
        total++;
        if (vec[it.sel] !== it.exp) begin
          bad++;
          $display("FAIL %s dut%0d: got %b expected %b", it.tag, it.sel,
                   vec[it.sel], it.exp);
        end
      end
    end
  end

  // Reset held two cycles: once the first edge has seen it, outputs are FETCH's.
  task automatic do_reset(int sel);
    logic r;
    r = rnd();
    cyc(sel, OP_R, 1'b0, 1'b1, '0, 1'b0, "reset_enter");
    cyc(sel, OP_R, r, 1'b1, (r || !mw[sel]) ? V_FRDY : V_FSTALL, 1'b1, "reset_hold");
  endtask

  task automatic trap_out(int sel);
    int n;
    n = 2 + int'($urandom % 3);
    for (int i = 0; i < n; i++)
      cyc(sel, 7'($urandom), rnd(), 1'b0, V_TRAP, 1'b1, "trap_hold");
    cyc(sel, OP_R, 1'b1, 1'b1, '0, 1'b0, "trap_reset");
    force_fs = 1'b1;
  endtask

  // fs/ms: cycles memory withholds mem_ready in FETCH / the data-memory state.
  // A wait longer than the timeout traps after timeout+1 stalled cycles.
  // abort_at: index of a MEMREAD stall cycle on which reset is pulsed.
  task automatic instr(int sel, logic [6:0] op, int fs, int ms, int abort_at);
    int T;
    bit w;
    T = tmo[sel];
    w = mw[sel];
    if (!w) begin
      fs = 0;
      ms = 0;
      abort_at = -1;
    end
    for (int i = 0; i < fs && i <= T; i++)
      cyc(sel, op, 1'b0, 1'b0, V_FSTALL, 1'b1, "fetch_stall");
    if (fs > T) begin
      trap_out(sel);
      return;
    end
    cyc(sel, op, w ? 1'b1 : rnd(), 1'b0, V_FRDY, 1'b1, "fetch");
    cyc(sel, op, rnd(), 1'b0, V_DEC, 1'b1, "decode");
    case (op)
      OP_LD: begin
        cyc(sel, op, rnd(), 1'b0, V_MADR, 1'b1, "memadr");
        for (int i = 0; i < ms && i <= T; i++) begin
          if (i == abort_at) begin
            cyc(sel, op, 1'b0, 1'b1, '0, 1'b0, "abort_reset");
            force_fs = 1'b1;
            return;
          end
          cyc(sel, op, 1'b0, 1'b0, V_MRD, 1'b1, "memread_stall");
        end
        if (ms > T) begin
          trap_out(sel);
          return;
        end
        cyc(sel, op, w ? 1'b1 : rnd(), 1'b0, V_MRD, 1'b1, "memread");
        cyc(sel, op, rnd(), 1'b0, V_MWB, 1'b1, "memwb");
      end
      OP_ST: begin
        cyc(sel, op, rnd(), 1'b0, V_MADR, 1'b1, "memadr");
        for (int i = 0; i < ms && i <= T; i++)
          cyc(sel, op, 1'b0, 1'b0, V_MWR_S, 1'b1, "memwrite_stall");
        if (ms > T) begin
          trap_out(sel);
          return;
        end
        cyc(sel, op, w ? 1'b1 : 1'b0, 1'b0, V_MWR_R, 1'b1, "memwrite");
      end
      OP_R: begin
        cyc(sel, op, rnd(), 1'b0, V_EXR, 1'b1, "execr");
        cyc(sel, op, rnd(), 1'b0, V_AWB, 1'b1, "aluwb");
      end
      OP_I: begin
        cyc(sel, op, rnd(), 1'b0, V_EXI, 1'b1, "execi");
        cyc(sel, op, rnd(), 1'b0, V_AWB, 1'b1, "aluwb");
      end
      OP_JAL: begin
        cyc(sel, op, rnd(), 1'b0, V_JAL, 1'b1, "jal");
        cyc(sel, op, rnd(), 1'b0, V_AWB, 1'b1, "aluwb");
      end
      OP_BR: cyc(sel, op, rnd(), 1'b0, V_BR, 1'b1, "branch");
      OP_JR, OP_LUI, OP_AUI: begin
        if (!ext[sel]) begin
          trap_out(sel);
          return;
        end
        if (op == OP_JR) begin
          cyc(sel, op, rnd(), 1'b0, V_JRA, 1'b1, "jalr_a");
          cyc(sel, op, rnd(), 1'b0, V_JRB, 1'b1, "jalr_b");
        end else begin
          cyc(sel, op, rnd(), 1'b0, (op == OP_LUI) ? V_LUI : V_AUI, 1'b1, "lui_auipc");
        end
        cyc(sel, op, rnd(), 1'b0, V_AWB, 1'b1, "aluwb");
      end
      default: trap_out(sel);
    endcase
  endtask

  logic [6:0] ops [11];

  initial begin
    int fs, ms, ab;
    logic [6:0] o;
    for (int i = 0; i < 3; i++) begin
      op_d[i]  = OP_R;
      rdy_d[i] = 1'b0;
      rst_d[i] = 1'b1;
    end
    ops = '{OP_LD, OP_ST, OP_R, OP_I, OP_JAL, OP_BR, OP_JR, OP_LUI, OP_AUI,
            7'b1111111, 7'b0000000};
    V_FSTALL = mk(0,0,1,0,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00);
    V_FRDY   = mk(0,0,1,0,1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00);
    V_DEC    = mk(0,0,0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00);
    V_MADR   = mk(0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00);
    V_MRD    = mk(0,0,1,0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00);
    V_MWB    = mk(0,1,0,0,0,1,0,0,0, 2'b01, 2'b00, 2'b00, 2'b00);
    V_MWR_S  = mk(0,0,1,0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00);
    V_MWR_R  = mk(0,1,1,0,0,0,1,0,1, 2'b00, 2'b00, 2'b00, 2'b00);
    V_EXR    = mk(0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10);
    V_EXI    = mk(0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10);
    V_AWB    = mk(0,1,0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00);
    V_JAL    = mk(0,0,0,0,1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00);
    V_BR     = mk(0,1,0,1,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b01);
    V_JRA    = mk(0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00);
    V_JRB    = mk(0,0,0,0,1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00);
    V_LUI    = mk(0,0,0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b01, 2'b00);
    V_AUI    = mk(0,0,0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00);
    V_TRAP   = mk(1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00);

    // Short-timeout instance: directed scenarios, then random traffic.
    do_reset(0);
    instr(0, OP_R, 0, 0, -1);
    instr(0, OP_R, 0, 0, -1);
    instr(0, OP_LD, 0, 3, -1);
    instr(0, OP_ST, 0, 4, -1);
    instr(0, OP_JR, tmo[0], 0, -1);
    instr(0, 7'b1111111, tmo[0], 0, -1);
    instr(0, OP_LD, tmo[0], 3, 2);
    instr(0, OP_ST, tmo[0], 3, -1);
    for (int n = 0; n < 80; n++) begin
      o  = ops[$urandom % 11];
      fs = force_fs ? tmo[0] : (($urandom % 8 == 0) ? tmo[0] + 1 : int'($urandom_range(0, 2)));
      force_fs = 1'b0;
      ms = ($urandom % 6 == 0) ? tmo[0] + 1 : int'($urandom_range(0, tmo[0]));
      ab = ($urandom % 5 == 0 && ms >= 2) ? int'($urandom_range(1, ms - 1)) : -1;
      instr(0, o, fs, ms, ab);
    end
    cyc(0, OP_R, 1'b0, 1'b1, '0, 1'b0, "park");

    // Extensions disabled, default timeout boundary.
    do_reset(1);
    instr(1, OP_JR, 0, 0, -1);
    instr(1, OP_LUI, 0, 0, -1);
    instr(1, OP_AUI, 15, 0, -1);
    instr(1, OP_LD, 0, 15, -1);
    instr(1, OP_ST, 2, 16, -1);
    instr(1, OP_I, 16, 0, -1);
    instr(1, OP_BR, 15, 0, -1);
    cyc(1, OP_R, 1'b0, 1'b1, '0, 1'b0, "park");

    // Memory wait disabled: mem_ready is driven randomly but must be ignored.
    do_reset(2);
    for (int n = 0; n < 20; n++)
      instr(2, ops[$urandom % 9], 0, 0, -1);

    repeat (3) @(posedge clk);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
